bus_fabric: RTL and testbench

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_fabric.sv | 204 ++++++++++++++++++++
 tb/tb_bus_fabric.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric.sv
// Single-master to NSLAVE-slave bus fabric.
// Decodes the master word address against per-slave byte regions, strobes
// the selected slave, waits for its ack with a bounded timeout and returns
// a one-cycle registered response. Unmapped accesses and timeouts give an
// error response and are counted in saturating error statistics.
module bus_fabric #(
    parameter int                   NSLAVE     = 4,
    parameter logic [NSLAVE*32-1:0] SLAVE_BASE = {32'd2048, 32'd1032, 32'd1028, 32'd1024},
    parameter logic [NSLAVE*32-1:0] SLAVE_SIZE = {32'd1024, 32'd4, 32'd4, 32'd4},
    parameter int                   TIMEOUT    = 16,
    parameter logic [31:0]          ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m_cyc,
    input  logic                   m_we,
    input  logic [29:0]            m_addr,
    input  logic [3:0]             m_sel,
    input  logic [31:0]            m_wdata,
    output logic [31:0]            m_rdata,
    output logic                   m_ack,
    output logic                   m_err,
    output logic                   s_cyc,
    output logic                   s_we,
    output logic [29:0]            s_addr,
    output logic [3:0]             s_sel,
    output logic [31:0]            s_wdata,
    output logic [NSLAVE-1:0]      s_stb,
    input  logic [NSLAVE-1:0]      s_ack,
    input  logic [NSLAVE*32-1:0]   s_rdata,
    output logic [7:0]             err_count,
    output logic [29:0]            err_addr
);

    localparam int         IDX_W     = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    // Returns {hit, index}; iterating downwards lets the lowest index win.
    // 33-bit compare keeps regions ending at 4 GiB from wrapping.
    function automatic logic [IDX_W:0] decode(input logic [29:0] addr);
        logic [32:0]    byte_a;
        logic [32:0]    lo;
        logic [32:0]    hi;
        logic [IDX_W:0] res;
        byte_a = {1'b0, addr, 2'b00};
        res    = {(IDX_W + 1){1'b0}};
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            lo = {1'b0, SLAVE_BASE[32*i +: 32]};
            hi = lo + {1'b0, SLAVE_SIZE[32*i +: 32]};
            if ((SLAVE_SIZE[32*i +: 32] != 32'd0) && (byte_a >= lo) && (byte_a < hi)) begin
                res = {1'b1, IDX_W'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NSLAVE-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NSLAVE-1:0] v;
        v      = {NSLAVE{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic [15:0]      cnt_r;
    logic [15:0]      cnt_nxt_s;
    logic             err_flag_r;
    logic             err_flag_nxt_s;
    logic             latch_s;
    logic [31:0]      rdata_nxt_s;
    logic [7:0]       err_count_nxt_s;
    logic [29:0]      err_addr_nxt_s;
    logic [IDX_W:0]   dec_s;
    logic             hit_s;
    logic [IDX_W-1:0] hit_idx_s;
    logic             ack_sel_s;
    logic [31:0]      ack_data_s;

    assign dec_s      = decode(m_addr);
    assign hit_s      = dec_s[IDX_W];
    assign hit_idx_s  = dec_s[IDX_W-1:0];
    // Only the latched slave's ack and data are ever looked at.
    assign ack_sel_s  = s_ack[idx_r];
    assign ack_data_s = s_rdata[32*int'(idx_r) +: 32];

    // Next-state, response-data and error-statistics computation.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        cnt_nxt_s       = cnt_r;
        err_flag_nxt_s  = err_flag_r;
        latch_s         = 1'b0;
        rdata_nxt_s     = m_rdata;
        err_count_nxt_s = err_count;
        err_addr_nxt_s  = err_addr;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 16'd0;
                if (m_cyc) begin
                    if (hit_s) begin
                        state_nxt_s    = ST_ACTIVE;
                        idx_nxt_s      = hit_idx_s;
                        latch_s        = 1'b1;
                        err_flag_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s     = ST_RESP;
                        err_flag_nxt_s  = 1'b1;
                        rdata_nxt_s     = ERR_DATA;
                        err_count_nxt_s = sat_inc(err_count);
                        err_addr_nxt_s  = m_addr;
                    end
                end else begin
                    err_flag_nxt_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                // Master withdrawal beats everything; ack beats timeout.
                if (!m_cyc) begin
                    state_nxt_s    = ST_IDLE;
                    cnt_nxt_s      = 16'd0;
                    err_flag_nxt_s = 1'b0;
                end else if (ack_sel_s) begin
                    state_nxt_s    = ST_RESP;
                    err_flag_nxt_s = 1'b0;
                    rdata_nxt_s    = ack_data_s;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s     = ST_RESP;
                    err_flag_nxt_s  = 1'b1;
                    rdata_nxt_s     = ERR_DATA;
                    err_count_nxt_s = sat_inc(err_count);
                    err_addr_nxt_s  = s_addr;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s    = ST_IDLE;
                err_flag_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                cnt_nxt_s      = 16'd0;
                err_flag_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched request and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            cnt_r      <= 16'd0;
            err_flag_r <= 1'b0;
            s_we       <= 1'b0;
            s_addr     <= 30'd0;
            s_sel      <= 4'd0;
            s_wdata    <= 32'd0;
            s_cyc      <= 1'b0;
            s_stb      <= {NSLAVE{1'b0}};
            m_ack      <= 1'b0;
            m_err      <= 1'b0;
            m_rdata    <= 32'd0;
            err_count  <= 8'd0;
            err_addr   <= 30'd0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            cnt_r      <= cnt_nxt_s;
            err_flag_r <= err_flag_nxt_s;
            if (latch_s) begin
                s_we    <= m_we;
                s_addr  <= m_addr;
                s_sel   <= m_sel;
                s_wdata <= m_wdata;
            end else begin
                s_we    <= s_we;
                s_addr  <= s_addr;
                s_sel   <= s_sel;
                s_wdata <= s_wdata;
            end
            s_cyc     <= (state_nxt_s == ST_ACTIVE);
            s_stb     <= (state_nxt_s == ST_ACTIVE) ? onehot(idx_nxt_s) : {NSLAVE{1'b0}};
            m_ack     <= (state_nxt_s == ST_RESP);
            m_err     <= (state_nxt_s == ST_RESP) && err_flag_nxt_s;
            m_rdata   <= rdata_nxt_s;
            err_count <= err_count_nxt_s;
            err_addr  <= err_addr_nxt_s;
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Randomised self-checking bench for bus_fabric with a transaction-level
// reference: expected slave, response latency, error and data are derived
// from the address map and the slave's chosen ack delay.
module tb_bus_fabric;

    localparam int TIMEOUT = 16;

    logic         clk;
    logic         rst_n;
    logic         m_cyc;
    logic         m_we;
    logic [29:0]  m_addr;
    logic [3:0]   m_sel;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic         m_ack;
    logic         m_err;
    logic         s_cyc;
    logic         s_we;
    logic [29:0]  s_addr;
    logic [3:0]   s_sel;
    logic [31:0]  s_wdata;
    logic [3:0]   s_stb;
    logic [3:0]   s_ack;
    logic [127:0] s_rdata;
    logic [7:0]   err_count;
    logic [29:0]  err_addr;

    bus_fabric dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata),
        .s_stb(s_stb), .s_ack(s_ack), .s_rdata(s_rdata),
        .err_count(err_count), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    longint      base_m [4] = '{1024, 1028, 1032, 2048};
    longint      size_m [4] = '{4, 4, 4, 1024};
    int          err_cnt_m  = 0;
    logic [29:0] err_addr_m = 30'd0;
    logic [31:0] rdata_m    = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [29:0] a);
        longint b;
        b = longint'({34'd0, a}) * 4;
        for (int i = 0; i < 4; i++) begin
            if (b >= base_m[i] && b < base_m[i] + size_m[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_slaves(input int tgt_mask_off);
        s_ack = 4'($urandom_range(0, 15));
        if (tgt_mask_off >= 0) s_ack[tgt_mask_off] = 1'b0;
        for (int i = 0; i < 4; i++) s_rdata[32*i +: 32] = $urandom();
    endtask

    task automatic model_error(input logic [29:0] a);
        if (err_cnt_m < 255) err_cnt_m++;
        err_addr_m = a;
        rdata_m    = 32'hDEADBEEF;
    endtask

    task automatic chk_stats();
        chk("m_rdata", m_rdata, rdata_m);
        chk("err_count", 32'(err_count), 32'(err_cnt_m));
        chk("err_addr", 32'(err_addr), 32'(err_addr_m));
    endtask

    // Idle cycles with m_cyc low; stray acks must be ignored.
    task automatic idle(input int n);
        m_cyc = 1'b0;
        for (int i = 0; i < n; i++) begin
            rand_slaves(-1);
            step();
            chk("idle_ack", 32'(m_ack), 32'd0);
            chk("idle_stb", 32'(s_stb), 32'd0);
            chk_stats();
        end
        s_ack = 4'd0;
    endtask

    // One master transaction. d = ACTIVE cycle on which the target acks
    // (>= TIMEOUT means never); abort_at >= 0 drops m_cyc on that cycle.
    task automatic run_txn(input logic [29:0] a, input logic we, input int d,
                           input int abort_at_in, input logic [31:0] ack_data);
        int          tgt;
        int          lat;
        int          ncyc;
        int          stb_end;
        int          abort_at;
        logic        err_exp;
        logic [3:0]  stb_exp;
        logic [3:0]  sel_v;
        logic [31:0] wd_v;
        tgt      = ref_decode(a);
        abort_at = (tgt < 0) ? -1 : abort_at_in;
        sel_v    = 4'($urandom_range(0, 15));
        wd_v     = $urandom();
        m_cyc = 1'b1; m_we = we; m_addr = a; m_sel = sel_v; m_wdata = wd_v;
        err_exp = 1'b0;
        if (tgt < 0) begin
            lat = 1; err_exp = 1'b1;
        end else if (abort_at >= 0) begin
            lat = -1;
        end else if (d < TIMEOUT) begin
            lat = d + 2;
        end else begin
            lat = TIMEOUT + 1; err_exp = 1'b1;
        end
        stb_end = (lat > 0) ? lat : abort_at + 2;
        ncyc    = (lat > 0) ? lat : abort_at + 3;
        for (int k = 1; k <= ncyc; k++) begin
            step();
            if (k == lat) begin
                if (err_exp) model_error(a);
                else rdata_m = ack_data;
            end
            stb_exp = (tgt >= 0 && k < stb_end) ? 4'(1 << tgt) : 4'd0;
            chk("s_stb", 32'(s_stb), 32'(stb_exp));
            chk("s_cyc", 32'(s_cyc), 32'(stb_exp != 4'd0));
            chk("m_ack", 32'(m_ack), 32'(k == lat));
            chk("m_err", 32'(m_err), 32'(k == lat && err_exp));
            chk_stats();
            if (stb_exp != 4'd0) begin
                chk("s_addr", 32'(s_addr), 32'(a));
                chk("s_we", 32'(s_we), 32'(we));
                chk("s_sel", 32'(s_sel), 32'(sel_v));
                chk("s_wdata", s_wdata, wd_v);
            end
            // Master keeps changing its bus; latched copies must not follow.
            m_addr = 30'($urandom()); m_wdata = $urandom(); m_we = ~we;
            rand_slaves((stb_exp != 4'd0) ? tgt : -1);
            if (stb_exp != 4'd0 && abort_at < 0 && (k - 1) == d) begin
                s_ack[tgt] = 1'b1;
                s_rdata[32*tgt +: 32] = ack_data;
            end
            if (abort_at >= 0 && (k - 1) == abort_at) m_cyc = 1'b0;
            if (k == lat) m_cyc = 1'b0;
        end
        m_cyc = 1'b0;
        s_ack = 4'd0;
    endtask

    initial begin
        logic [29:0] a;
        int          d;
        int          ab;
        int          r;
        logic [29:0] edges [6] = '{30'd255, 30'd259, 30'd511, 30'd767, 30'd768, 30'h3FFFFFFF};

        rst_n = 1'b0; m_cyc = 1'b0; m_we = 1'b0; m_addr = 30'd0; m_sel = 4'd0;
        m_wdata = 32'd0; s_ack = 4'd0; s_rdata = 128'd0;
        repeat (3) step();
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_stb", 32'(s_stb), 32'd0);
        chk("rst_cyc", 32'(s_cyc), 32'd0);
        chk_stats();
        rst_n = 1'b1;
        idle(2);

        run_txn(30'd256, 1'b1, 0, -1, 32'hA5A5_0001);          // slave 0, ack first cycle
        idle(1);
        run_txn(30'd600, 1'b0, 3, -1, 32'h12345678);           // slave 3, ack after 3
        idle(1);
        run_txn(30'd0, 1'b0, 0, -1, 32'h0);                    // unmapped
        idle(1);
        run_txn(30'd257, 1'b0, 100, -1, 32'h0);                // slave 1 timeout
        idle(1);
        run_txn(30'd258, 1'b1, TIMEOUT - 1, -1, 32'hCAFE_F00D); // ack on timeout cycle
        idle(1);
        run_txn(30'd767, 1'b1, 10, 4, 32'h0);                  // abort
        idle(1);

        // m_cyc held across the response starts the next request after RESP
        m_cyc = 1'b1; m_we = 1'b0; m_addr = 30'd5;
        step();
        model_error(30'd5);
        chk("b2b_ack1", 32'(m_ack), 32'd1);
        chk("b2b_err1", 32'(m_err), 32'd1);
        m_addr = 30'd6;
        step();
        chk("b2b_gap", 32'(m_ack), 32'd0);
        step();
        model_error(30'd6);
        chk("b2b_ack2", 32'(m_ack), 32'd1);
        chk_stats();
        idle(1);

        // Reset in the middle of a transaction
        m_cyc = 1'b1; m_addr = 30'd256;
        step();
        chk("mid_stb", 32'(s_stb), 32'd1);
        rst_n = 1'b0;
        step();
        err_cnt_m = 0; err_addr_m = 30'd0; rdata_m = 32'd0;
        chk("mrst_stb", 32'(s_stb), 32'd0);
        chk("mrst_cyc", 32'(s_cyc), 32'd0);
        chk("mrst_ack", 32'(m_ack), 32'd0);
        chk_stats();
        rst_n = 1'b1;
        idle(2);

        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: a = 30'(256 + $urandom_range(0, 3));
                1: a = 30'(512 + $urandom_range(0, 255));
                2: a = edges[$urandom_range(0, 5)];
                3: a = 30'($urandom());
                default: a = 30'($urandom_range(0, 1023));
            endcase
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 5);
            ab = -1;
            if ($urandom_range(0, 7) == 0 && d > 1)
                ab = $urandom_range(0, (d - 1 < TIMEOUT - 2) ? d - 1 : TIMEOUT - 2);
            run_txn(a, 1'($urandom_range(0, 1)), d, ab, $urandom());
            idle($urandom_range(1, 2));
        end

        for (int t = 0; t < 300; t++) begin
            run_txn(30'($urandom_range(0, 255)), 1'b0, 0, -1, 32'h0);
            idle(1);
        end
        chk("sat_count", 32'(err_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
